// File: rtl/data_mem_access.sv
// RV32I memory-access pipeline stage: issues load/store requests, waits out the
// memory handshake, aligns store data, extracts load data, and drives the MEM/WB register.
package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [3:0]  aluop;
    logic [2:0]  regfilemux_sel;
    logic        load_regfile;
    logic [4:0]  rd;
  } rv32i_control_word;
endpackage

module data_mem_access
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  rv32i_control_word ctrl_word_in,
  input  logic [31:0]       instruction_in,
  input  logic [31:0]       PC_in,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       rs2_in,
  input  logic              br_en_in,
  input  logic [3:0]        mem_byte_enable_in,
  input  logic [1:0]        addr_offset_in,
  input  logic [31:0]       data_rdata,
  input  logic              data_resp,
  output logic              data_read,
  output logic              data_write,
  output logic [3:0]        data_mbe,
  output logic [31:0]       data_addr,
  output logic [31:0]       data_wdata,
  output logic              MA_stall,
  output rv32i_control_word ctrl_word_out,
  output logic [31:0]       instruction_out,
  output logic [31:0]       PC_out,
  output logic [31:0]       alu_out,
  output logic [31:0]       mdr_out,
  output logic              br_en_out
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int CW_W = $bits(rv32i_control_word);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_mem_op;
  logic [4:0]        w_shamt;
  logic [31:0]       w_shifted;
  logic [31:0]       w_load_val;
  logic [CW_W-1:0]   r_ctrl_word;
  logic [31:0]       r_instruction;
  logic [31:0]       r_pc;
  logic [31:0]       r_alu;
  logic [31:0]       r_mdr;
  logic              r_br_en;

  // Gating with rst keeps requests low for the whole time reset is held.
  assign w_is_load  = rst && (ctrl_word_in.opcode == op_load);
  assign w_is_store = rst && (ctrl_word_in.opcode == op_store);
  assign w_mem_op   = w_is_load || w_is_store;
  assign w_shamt    = {addr_offset_in, 3'b000};

  assign data_read  = w_is_load;
  assign data_write = w_is_store;
  assign data_mbe   = w_is_store ? mem_byte_enable_in : 4'b0000;
  assign data_addr  = {alu_in[31:2], 2'b00};
  assign data_wdata = rs2_in << w_shamt;
  assign MA_stall   = w_mem_op && !data_resp;

  // Request/response handshake state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; BUSY falls back to IDLE if the op disappears.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_mem_op && !data_resp) begin
          w_next_state = BUSY;
        end else begin
          w_next_state = IDLE;
        end
      end
      BUSY: begin
        if (data_resp || !w_mem_op) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = BUSY;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Load data: shift the addressed lane down, then truncate and extend by funct3.
  always_comb begin
    w_shifted  = data_rdata >> w_shamt;
    w_load_val = w_shifted;
    case (instruction_in[14:12])
      3'b000:  w_load_val = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_val = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load_val = w_shifted;
      3'b100:  w_load_val = {24'h000000, w_shifted[7:0]};
      3'b101:  w_load_val = {16'h0000, w_shifted[15:0]};
      default: w_load_val = w_shifted;
    endcase
  end

  // MEM/WB pipeline register; frozen while the stage is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl_word   <= {CW_W{1'b0}};
      r_instruction <= 32'h0000_0000;
      r_pc          <= 32'h0000_0000;
      r_alu         <= 32'h0000_0000;
      r_mdr         <= 32'h0000_0000;
      r_br_en       <= 1'b0;
    end else if (!MA_stall) begin
      r_ctrl_word   <= ctrl_word_in;
      r_instruction <= instruction_in;
      r_pc          <= PC_in;
      r_alu         <= alu_in;
      r_br_en       <= br_en_in;
      if (w_is_load && data_resp) begin
        r_mdr <= w_load_val;
      end else begin
        r_mdr <= r_mdr;
      end
    end else begin
      r_ctrl_word   <= r_ctrl_word;
      r_instruction <= r_instruction;
      r_pc          <= r_pc;
      r_alu         <= r_alu;
      r_mdr         <= r_mdr;
      r_br_en       <= r_br_en;
    end
  end

  assign ctrl_word_out   = rv32i_control_word'(r_ctrl_word);
  assign instruction_out = r_instruction;
  assign PC_out          = r_pc;
  assign alu_out         = r_alu;
  assign mdr_out         = r_mdr;
  assign br_en_out       = r_br_en;

endmodule
